pixel_stream_framer: RTL and testbench
======================================

// Module: pixel_stream_framer
// PURPOSE
// - Next-generation frame sequencer between the pixel generator and the video output stream.
// - Walks raster coordinates and tells the generator which pixel to produce.
// - Accepts colours over valid/ready and emits a buffered packet stream with SOP, EOL and EOP markers.
// - Adds runtime resolution (within compile-time maxima), a frame counter and a 2-entry skid buffer.
// PARAMETERS
// - DATA_WIDTH  10   coordinate width; MAX_WIDTH and MAX_HEIGHT must both be <= 2**DATA_WIDTH
// - RGB_SIZE    24   colour word width
// - MAX_WIDTH   640  largest legal line length, in pixels
// - MAX_HEIGHT  480  largest legal line count
// - FRAME_CNT_W 8    frame counter width
// PORTS
// - clk         in   1            system clock, rising edge
// - reset_n     in   1            asynchronous, active-low reset
// - cfg_width   in   DATA_WIDTH   requested active width
// - cfg_height  in   DATA_WIDTH   requested active height
// - cfg_load    in   1            1-cycle strobe that samples cfg_width and cfg_height
// - gen_x       out  DATA_WIDTH   x of the pixel the generator must present now
// - gen_y       out  DATA_WIDTH   y of the pixel the generator must present now
// - gen_first   out  1            gen_x==0 && gen_y==0
// - gen_last_x  out  1            gen_x==act_w-1
// - gen_last_y  out  1            gen_y==act_h-1
// - in_valid    in   1            generator has in_colour for (gen_x, gen_y)
// - in_ready    out  1            framer accepts this cycle
// - in_colour   in   RGB_SIZE     pixel colour
// - out_valid   out  1            stream beat valid
// - out_ready   in   1            downstream accepts
// - out_colour  out  RGB_SIZE     beat colour
// - out_sop     out  1            first pixel of the frame
// - out_eol     out  1            last pixel of a line
// - out_eop     out  1            last pixel of the frame
// - frame_count out  FRAME_CNT_W  number of completed frames accepted; wraps
// BEHAVIOUR
// Reset (async assert, sync release)
// - gen_x=0, gen_y=0; both skid entries empty; out_valid=0; out_colour/sop/eol/eop=0; frame_count=0.
// - act_w=MAX_WIDTH, act_h=MAX_HEIGHT; pending config cleared.
// - Reset mid-frame drops all buffered beats. The next accepted pixel is (0,0) with SOP.
// Handshake
// - A pixel is accepted when in_valid && in_ready.
// - in_ready=1 when at least one skid entry is free; it is registered and does not depend on out_ready.
// - gen_x/gen_y are registered and change only on acceptance.
// - Sequencing on acceptance:
//   - x<act_w-1: x++
//   - else if y<act_h-1: x=0, y++
//   - else: x=0, y=0, frame_count++ (modulo 2**FRAME_CNT_W)
// - The beat is tagged from the accepted coordinates: sop=(x==0&&y==0), eol=(x==act_w-1), eop=eol&&(y==act_h-1).
// - Latency: accept in cycle N -> out_valid in cycle N+1 when the buffer was empty.
// - Throughput: 1 beat/cycle sustained while out_ready=1.
// - Beats leave in order. A beat is held stable while out_valid && !out_ready. None lost or duplicated.
// Configuration
// - cfg_load latches a clamped pair into pending registers. The last strobe wins.
// - Clamping: 0 -> 1; a value above MAX -> MAX.
// - Pending applies to act_w/act_h only when the coordinates are (0,0).
//   - At (0,0) with no frame in progress: applies on the next cycle.
//   - Mid-frame: applies on the cycle after the EOP pixel is accepted.
// - The frame in progress always completes at its old size.
// Simultaneous events
// - cfg_load on the same cycle as EOP acceptance: the new config applies to the next frame.
// - Accept and drain in the same cycle with one entry full: occupancy stays 1.
// STRUCTURE
// - video_pkg holds:
//   - typedef pixel_beat_t: packed struct {colour, sop, eol, eop}
//   - localparams for default RGB_SIZE/DATA_WIDTH
//   - function clamp_dim()
// - Sub-module stream_skid_buffer #(type T): 2-entry valid/ready skid; registered ready.
// - The top level holds the coordinate counters, config registers and frame counter.
// TESTING
// - cfg 4x3, load, in_valid=1, out_ready=1:
//   - 12 beats; sop on beat 1; eol on beats 4,8,12; eop on beat 12
//   - frame_count 0->1; gen returns to (0,0)
// - Same as above with out_ready toggled 1,0,0,1 repeatedly:
//   - colours out == colours in, in order
//   - in_ready falls after 2 stalled beats
//   - out_colour stable while stalled
// - cfg_load 8x2 at pixel (2,1) of a 4x3 frame:
//   - current frame still ends at 12 beats with eop
//   - next frame: eop on beat 16, eol on beats 8,16
// - cfg_width=0, cfg_height=1000:
//   - frame is 1 x MAX_HEIGHT(480)
//   - every beat has eol; eop on beat 480
// - reset_n low for 1 cycle at pixel (3,1) with 2 beats buffered:
//   - out_valid=0, frame_count=0 immediately
//   - next beat is sop at (0,0), size MAX
// - 256 back-to-back 1x1 frames:
//   - frame_count wraps 255->0
//   - every beat carries sop=eol=eop=1

Source files
------------

// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared types and helpers for the pixel streaming blocks.
//   DEFAULT_RGB_SIZE / DEFAULT_DATA_WIDTH : default colour / coordinate widths
//   pixel_beat_t                          : one stream beat {colour, sop, eol, eop}
//   clamp_dim()                           : forces a requested dimension into 1..max
// ---------------------------------------------------------------------------
package video_pkg;

  localparam int DEFAULT_RGB_SIZE   = 24;
  localparam int DEFAULT_DATA_WIDTH = 10;

  typedef struct packed {
    logic [DEFAULT_RGB_SIZE-1:0] colour;
    logic                        sop;
    logic                        eol;
    logic                        eop;
  } pixel_beat_t;

  // A zero dimension would make the raster walk degenerate, so it becomes 1.
  function automatic int unsigned clamp_dim(input int unsigned req,
                                            input int unsigned max_dim);
    int unsigned result;
    result = req;
    if (req == 0) begin
      result = 1;
    end else if (req > max_dim) begin
      result = max_dim;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// ---------------------------------------------------------------------------
// stream_skid_buffer
// Two-entry valid/ready buffer with a registered input-side ready, so the
// upstream ready never combinationally depends on the downstream ready.
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake, in_data payload
//   out_valid/out_ready   : downstream handshake, out_data payload
// ---------------------------------------------------------------------------
module stream_skid_buffer #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  T           entry_reg [0:1];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       ready_reg;

  logic       push;
  logic       pop;
  logic [1:0] count_next;

  assign push       = in_valid && ready_reg;
  assign pop        = (count_reg != 2'd0) && out_ready;
  assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_reg[0] <= '0;
      entry_reg[1] <= '0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      ready_reg    <= 1'b1;
    end else begin
      if (push) begin
        entry_reg[wr_ptr_reg] <= in_data;
        wr_ptr_reg            <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_next;
      // Ready is computed from the post-update occupancy so a simultaneous
      // push and pop with one entry full keeps accepting.
      ready_reg <= (count_next != 2'd2);
    end
  end

  assign in_ready  = ready_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = entry_reg[rd_ptr_reg];

endmodule

// File: rtl/pixel_stream_framer.sv
// ---------------------------------------------------------------------------
// pixel_stream_framer
// Walks raster coordinates for the pixel generator, accepts colours over
// valid/ready and emits a buffered stream tagged with SOP/EOL/EOP.
//   clk, reset_n                    : clock, asynchronous active-low reset
//   cfg_width/cfg_height/cfg_load   : runtime resolution request (clamped)
//   gen_x/gen_y/gen_first/gen_last_*: pixel the generator must present now
//   in_valid/in_ready/in_colour     : colour input handshake
//   out_valid/out_ready/out_colour,
//   out_sop/out_eol/out_eop         : packet stream output
//   frame_count                     : completed frames accepted (wraps)
// ---------------------------------------------------------------------------
module pixel_stream_framer
  import video_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int RGB_SIZE    = DEFAULT_RGB_SIZE,
  parameter int MAX_WIDTH   = 640,
  parameter int MAX_HEIGHT  = 480,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_WIDTH-1:0]  cfg_width,
  input  logic [DATA_WIDTH-1:0]  cfg_height,
  input  logic                   cfg_load,
  output logic [DATA_WIDTH-1:0]  gen_x,
  output logic [DATA_WIDTH-1:0]  gen_y,
  output logic                   gen_first,
  output logic                   gen_last_x,
  output logic                   gen_last_y,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RGB_SIZE-1:0]    in_colour,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RGB_SIZE-1:0]    out_colour,
  output logic                   out_sop,
  output logic                   out_eol,
  output logic                   out_eop,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  // Dimensions may equal 2**DATA_WIDTH, so they carry one extra bit.
  localparam int DIM_W = DATA_WIDTH + 1;

  // Same layout as pixel_beat_t, but sized by this instance's RGB_SIZE.
  typedef struct packed {
    logic [RGB_SIZE-1:0] colour;
    logic                sop;
    logic                eol;
    logic                eop;
  } beat_t;

  logic [DATA_WIDTH-1:0]  x_reg;
  logic [DATA_WIDTH-1:0]  y_reg;
  logic [DIM_W-1:0]       act_w_reg;
  logic [DIM_W-1:0]       act_h_reg;
  logic [DIM_W-1:0]       pend_w_reg;
  logic [DIM_W-1:0]       pend_h_reg;
  logic                   pend_valid_reg;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg;

  logic             at_origin;
  logic             use_pend;
  logic [DIM_W-1:0] eff_w;
  logic [DIM_W-1:0] eff_h;
  logic             last_x;
  logic             last_y;
  logic             accept;
  logic             skid_ready;
  logic [DIM_W-1:0] cfg_w_clamped;
  logic [DIM_W-1:0] cfg_h_clamped;
  beat_t            beat_in;
  beat_t            beat_out;

  assign at_origin = (x_reg == '0) && (y_reg == '0);

  // A pending size takes over while the raster sits at (0,0). The effective
  // size is forwarded combinationally so a pixel accepted at (0,0) in the
  // same cycle already belongs to the new-size frame instead of starting a
  // frame whose size would change under it.
  assign use_pend = pend_valid_reg && at_origin;
  assign eff_w    = use_pend ? pend_w_reg : act_w_reg;
  assign eff_h    = use_pend ? pend_h_reg : act_h_reg;

  assign last_x = ({1'b0, x_reg} == (eff_w - DIM_W'(1)));
  assign last_y = ({1'b0, y_reg} == (eff_h - DIM_W'(1)));

  assign accept = in_valid && skid_ready;

  assign cfg_w_clamped = DIM_W'(clamp_dim(32'(cfg_width), MAX_WIDTH));
  assign cfg_h_clamped = DIM_W'(clamp_dim(32'(cfg_height), MAX_HEIGHT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_reg          <= '0;
      y_reg          <= '0;
      act_w_reg      <= DIM_W'(MAX_WIDTH);
      act_h_reg      <= DIM_W'(MAX_HEIGHT);
      pend_w_reg     <= '0;
      pend_h_reg     <= '0;
      pend_valid_reg <= 1'b0;
      frame_cnt_reg  <= '0;
    end else begin
      if (use_pend) begin
        act_w_reg <= pend_w_reg;
        act_h_reg <= pend_h_reg;
      end

      // A new strobe overrides whatever is pending, even one being applied now.
      if (cfg_load) begin
        pend_w_reg     <= cfg_w_clamped;
        pend_h_reg     <= cfg_h_clamped;
        pend_valid_reg <= 1'b1;
      end else if (use_pend) begin
        pend_valid_reg <= 1'b0;
      end

      if (accept) begin
        if (!last_x) begin
          x_reg <= x_reg + DATA_WIDTH'(1);
        end else if (!last_y) begin
          x_reg <= '0;
          y_reg <= y_reg + DATA_WIDTH'(1);
        end else begin
          x_reg         <= '0;
          y_reg         <= '0;
          frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    beat_in        = '0;
    beat_in.colour = in_colour;
    beat_in.sop    = at_origin;
    beat_in.eol    = last_x;
    beat_in.eop    = last_x && last_y;
  end

  stream_skid_buffer #(
    .T(beat_t)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (skid_ready),
    .in_data   (beat_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (beat_out)
  );

  assign in_ready    = skid_ready;
  assign out_colour  = beat_out.colour;
  assign out_sop     = beat_out.sop;
  assign out_eol     = beat_out.eol;
  assign out_eop     = beat_out.eop;

  assign gen_x       = x_reg;
  assign gen_y       = y_reg;
  assign gen_first   = at_origin;
  assign gen_last_x  = last_x;
  assign gen_last_y  = last_y;
  assign frame_count = frame_cnt_reg;

endmodule

// File: tb/tb_pixel_stream_framer.sv
// ---------------------------------------------------------------------------
// tb_pixel_stream_framer
// Directed sequence with randomized colours and handshakes, checked against
// a pixel-index reference model: each frame is a run of w*h pixels whose
// markers follow from the index alone, and the buffer is an ordered queue.
// ---------------------------------------------------------------------------
module tb_pixel_stream_framer;

  localparam int MAXW = 640;
  localparam int MAXH = 480;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  cfg_width;
  logic [9:0]  cfg_height;
  logic        cfg_load;
  logic [9:0]  gen_x;
  logic [9:0]  gen_y;
  logic        gen_first;
  logic        gen_last_x;
  logic        gen_last_y;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_colour;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_colour;
  logic        out_sop;
  logic        out_eol;
  logic        out_eop;
  logic [7:0]  frame_count;

  always #5 clk = ~clk;

  pixel_stream_framer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .cfg_load    (cfg_load),
    .gen_x       (gen_x),
    .gen_y       (gen_y),
    .gen_first   (gen_first),
    .gen_last_x  (gen_last_x),
    .gen_last_y  (gen_last_y),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_colour   (in_colour),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_colour  (out_colour),
    .out_sop     (out_sop),
    .out_eol     (out_eol),
    .out_eop     (out_eop),
    .frame_count (frame_count)
  );

  typedef struct packed {
    logic [23:0] colour;
    logic        sop;
    logic        eol;
    logic        eop;
  } beat_t;

  beat_t      exp_q[$];
  int         m_idx, m_w, m_h, m_pw, m_ph;
  bit         m_pend;
  logic [7:0] m_frames;
  int         m_eops, m_accepts;
  bit         prev_stall;
  beat_t      prev_beat;
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int mx);
    if (v == 0) return 1;
    if (v > mx) return mx;
    return v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_idx = 0; m_w = MAXW; m_h = MAXH; m_pw = 0; m_ph = 0;
    m_pend = 0; m_frames = 8'd0; prev_stall = 0; prev_beat = '0;
  endtask

  // Called at a falling edge with inputs already driven; checks the DUT,
  // updates the model with this cycle's handshakes, advances one cycle.
  task automatic tick();
    int    w_now, h_now;
    beat_t b, got;
    w_now = (m_idx == 0 && m_pend) ? m_pw : m_w;
    h_now = (m_idx == 0 && m_pend) ? m_ph : m_h;
    chk("in_ready",    in_ready,    exp_q.size() < 2);
    chk("out_valid",   out_valid,   exp_q.size() != 0);
    chk("frame_count", frame_count, m_frames);
    chk("gen_x",       gen_x,       m_idx % w_now);
    chk("gen_y",       gen_y,       m_idx / w_now);
    chk("gen_first",   gen_first,   m_idx == 0);
    chk("gen_last_x",  gen_last_x,  (m_idx % w_now) == w_now - 1);
    chk("gen_last_y",  gen_last_y,  (m_idx / w_now) == h_now - 1);
    got = {out_colour, out_sop, out_eol, out_eop};
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_hold",  got, prev_beat);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("beat_unexpected", out_valid, 0);
      else begin
        b = exp_q.pop_front();
        chk("beat", got, b);
      end
    end
    if (in_valid && in_ready) begin
      if (m_idx == 0 && m_pend) begin
        m_w = m_pw; m_h = m_ph; m_pend = 0;
      end
      b.colour = in_colour;
      b.sop    = (m_idx == 0);
      b.eol    = ((m_idx + 1) % m_w) == 0;
      b.eop    = (m_idx == m_w * m_h - 1);
      exp_q.push_back(b);
      m_accepts++;
      m_idx++;
      if (m_idx == m_w * m_h) begin
        m_idx = 0; m_frames++; m_eops++;
      end
    end
    if (cfg_load) begin
      m_pw = clamp(int'(cfg_width), MAXW);
      m_ph = clamp(int'(cfg_height), MAXH);
      m_pend = 1;
    end
    prev_stall = out_valid && !out_ready;
    prev_beat  = got;
    @(negedge clk);
  endtask

  // mode 0: full rate, 1: out_ready pattern 1,0,0,1, 2: random, 3: stalled
  task automatic drive(input int mode, input int cyc);
    in_colour = $urandom;
    in_valid  = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       out_ready = $urandom_range(0, 1) != 0;
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic drain(input int budget);
    int cyc = 0;
    in_valid = 0; out_ready = 1;
    while (exp_q.size() != 0 && cyc < budget) begin tick(); cyc++; end
    chk("drain_timeout", cyc < budget, 1);
  endtask

  task automatic run_frames(input int n, input int mode, input int budget);
    int target = m_eops + n;
    int cyc = 0;
    while (m_eops < target && cyc < budget) begin drive(mode, cyc); tick(); cyc++; end
    chk("frames_timeout", m_eops >= target, 1);
    drain(budget);
  endtask

  task automatic run_accepts(input int n, input int mode, input int budget);
    int target = m_accepts + n;
    int cyc = 0;
    while (m_accepts < target && cyc < budget) begin drive(mode, cyc); tick(); cyc++; end
    chk("accepts_timeout", m_accepts >= target, 1);
    in_valid = 0;
  endtask

  task automatic load_cfg(input int w, input int h);
    cfg_width = 10'(w); cfg_height = 10'(h); cfg_load = 1;
    in_valid = 0; out_ready = 1;
    tick();
    cfg_load = 0;
  endtask

  initial begin
    m_eops = 0; m_accepts = 0;
    reset_n = 0; cfg_width = 0; cfg_height = 0; cfg_load = 0;
    in_valid = 0; in_colour = 0; out_ready = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_gen_x",       gen_x, 0);
    chk("rst_gen_y",       gen_y, 0);
    chk("rst_out_valid",   out_valid, 0);
    chk("rst_out_beat",    {out_colour, out_sop, out_eol, out_eop}, 0);
    chk("rst_frame_count", frame_count, 0);
    reset_n = 1;
    @(negedge clk);

    // 4x3 at full rate, then with stalls
    load_cfg(4, 3);
    run_frames(1, 0, 100);
    chk("4x3_frame_count", frame_count, 1);
    chk("4x3_back_origin", {gen_x, gen_y}, 0);
    run_frames(1, 1, 200);

    // 8x2 requested at pixel (2,1) of a 4x3 frame
    run_accepts(6, 0, 50);
    cfg_width = 8; cfg_height = 2; cfg_load = 1;
    drive(0, 0);
    tick();
    cfg_load = 0;
    run_frames(2, 0, 300);

    // random handshakes on a 5x4 frame
    load_cfg(5, 4);
    run_frames(3, 2, 1000);

    // clamping: 0 -> 1, 1000 -> 480
    load_cfg(0, 1000);
    run_frames(1, 2, 5000);

    // reset at (3,1) of a 4x3 frame with two beats buffered
    load_cfg(4, 3);
    run_accepts(5, 0, 50);
    drain(10);
    run_accepts(2, 3, 10);
    chk("pre_rst_pos", {gen_x, gen_y}, {10'd3, 10'd1});
    reset_n = 0;
    #1;
    chk("mid_rst_out_valid",   out_valid, 0);
    chk("mid_rst_frame_count", frame_count, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    run_accepts(20, 0, 100);
    drain(10);

    // 256 one-pixel frames wrap the counter
    reset_n = 0;
    @(negedge clk);
    model_reset();
    reset_n = 1;
    @(negedge clk);
    load_cfg(1, 1);
    run_frames(256, 0, 2000);
    chk("wrap_frame_count", frame_count, 0);
    run_frames(1, 2, 100);
    chk("post_wrap_count", frame_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
